// File: rtl/estimator_valid_pkg.sv
// Shared types and defaults for the estimator valid generator.
// State encoding, parameter defaults and counter sizing.
package estimator_valid_pkg;

  typedef enum logic [1:0] {
    S_WARMUP = 2'd0,
    S_TRACK  = 2'd1,
    S_LOCKED = 2'd2
  } state_e;

  localparam int          DATA_W_DEF = 32;
  localparam int unsigned TOL_DEF    = 32'd1024;
  localparam int          WARMUP_DEF = 16;
  localparam int          SETTLE_DEF = 64;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/abs_diff_reg.sv
// Stage 1: registered |y - yhat|, registered yhat and a
// one-enabled-cycle valid qualifier for stage 2.
module abs_diff_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ce_i,
  input  logic              stb_i,
  input  logic [DATA_W-1:0] y_i,
  input  logic [DATA_W-1:0] yhat_i,
  output logic [DATA_W-1:0] err_abs_o,
  output logic [DATA_W-1:0] yhat_o,
  output logic              err_vld_o
);

  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] mag;
  logic [DATA_W-1:0] err_q, err_d;
  logic [DATA_W-1:0] yhat_q, yhat_d;
  logic              vld_q, vld_d;

  // Magnitude fits DATA_W bits, so only the low bits are negated
  assign diff = {y_i[DATA_W-1], y_i}
              - {yhat_i[DATA_W-1], yhat_i};
  assign mag  = diff[DATA_W] ? (~diff[DATA_W-1:0] + 1'b1)
                             : diff[DATA_W-1:0];

  always_comb begin
    err_d  = err_q;
    yhat_d = yhat_q;
    vld_d  = vld_q;
    if (ce_i) begin
      vld_d = stb_i;
      if (stb_i) begin
        err_d  = mag;
        yhat_d = yhat_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q  <= '0;
      yhat_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      err_q  <= err_d;
      yhat_q <= yhat_d;
      vld_q  <= vld_d;
    end
  end

  assign err_abs_o = err_q;
  assign yhat_o    = yhat_q;
  assign err_vld_o = vld_q;

endmodule

// File: rtl/estimator_valid_gen.sv
// Sticky estimate-valid flag: warm-up skip, then lock after
// SETTLE_COUNT consecutive in-tolerance samples.
module estimator_valid_gen
  import estimator_valid_pkg::*;
#(
  parameter int          DATA_W       = DATA_W_DEF,
  parameter int unsigned TOL          = TOL_DEF,
  parameter int          WARMUP       = WARMUP_DEF,
  parameter int          SETTLE_COUNT = SETTLE_DEF
) (
  input  logic                             clk_1,
  input  logic                             rst_1,
  input  logic                             ce_1,
  input  logic                             sample_stb,
  input  logic [DATA_W-1:0]                y,
  input  logic [DATA_W-1:0]                yhat,
  output logic [DATA_W-1:0]                yhat_out,
  output logic                             valid,
  output logic [DATA_W-1:0]                err_abs,
  output logic [cnt_w(SETTLE_COUNT)-1:0]   settle_cnt
);

  localparam int SW = cnt_w(SETTLE_COUNT);
  localparam int WW = (WARMUP > 0) ? cnt_w(WARMUP) : 1;
  localparam logic [SW-1:0]     SC_L  = SW'(SETTLE_COUNT);
  localparam logic [WW-1:0]     WU_L  = WW'(WARMUP);
  localparam logic [DATA_W-1:0] TOL_L = DATA_W'(TOL);
  localparam state_e RST_ST = (WARMUP == 0) ? S_TRACK : S_WARMUP;

  state_e          state_q, state_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic            valid_q, valid_d;
  logic            err_vld;
  logic            step;
  logic            good;

  abs_diff_reg #(
    .DATA_W (DATA_W)
  ) u_stage1 (
    .clk_i     (clk_1),
    .rst_i     (rst_1),
    .ce_i      (ce_1),
    .stb_i     (sample_stb),
    .y_i       (y),
    .yhat_i    (yhat),
    .err_abs_o (err_abs),
    .yhat_o    (yhat_out),
    .err_vld_o (err_vld)
  );

  assign step = ce_1 & err_vld;
  assign good = (err_abs <= TOL_L);

  always_ff @(posedge clk_1) begin
    if (rst_1) begin
      state_q <= RST_ST;
    end else if (ce_1) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (step) begin
      unique case (state_q)
        S_WARMUP: begin
          if (wcnt_q + 1'b1 == WU_L) state_d = S_TRACK;
        end
        S_TRACK: begin
          if (good && (scnt_q + 1'b1 == SC_L))
            state_d = S_LOCKED;
        end
        default: ;
      endcase
    end
  end

  // Counters and the sticky flag follow the state decision
  always_comb begin
    wcnt_d  = wcnt_q;
    scnt_d  = scnt_q;
    valid_d = valid_q;
    if (step) begin
      unique case (state_q)
        S_WARMUP: wcnt_d = wcnt_q + 1'b1;
        S_TRACK:  scnt_d = good ? scnt_q + 1'b1 : '0;
        default: ;
      endcase
    end
    if (state_d == S_LOCKED) valid_d = 1'b1;
  end

  always_ff @(posedge clk_1) begin
    if (rst_1) begin
      wcnt_q  <= '0;
      scnt_q  <= '0;
      valid_q <= 1'b0;
    end else if (ce_1) begin
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
      valid_q <= valid_d;
    end
  end

  assign valid      = valid_q;
  assign settle_cnt = scnt_q;

endmodule

// File: tb/tb_estimator_valid_gen.sv
// Bench for estimator_valid_gen: default instance plus a
// WARMUP=0 / SETTLE_COUNT=4 instance sharing the stimulus.
module tb_estimator_valid_gen;

  localparam int     WU   = 16;
  localparam int     SC   = 64;
  localparam longint TOLV = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ce, stb;
  logic [31:0] y, yh;
  logic [31:0] yo, ea, yo0, ea0;
  logic        v, v0;
  logic [6:0]  sc;
  logic [2:0]  sc0;

  int errors = 0;
  int checks = 0;

  // Reference model of the default instance, sample by sample
  int          m_n, m_run;
  bit          m_lock;
  logic [31:0] m_err, m_yh;

  estimator_valid_gen dut (
    .clk_1 (clk), .rst_1 (rst), .ce_1 (ce),
    .sample_stb (stb), .y (y), .yhat (yh),
    .yhat_out (yo), .valid (v), .err_abs (ea),
    .settle_cnt (sc)
  );

  estimator_valid_gen #(
    .WARMUP (0), .SETTLE_COUNT (4)
  ) dut0 (
    .clk_1 (clk), .rst_1 (rst), .ce_1 (ce),
    .sample_stb (stb), .y (y), .yhat (yh),
    .yhat_out (yo0), .valid (v0), .err_abs (ea0),
    .settle_cnt (sc0)
  );

  task automatic model_rst();
    m_n = 0; m_run = 0; m_lock = 0;
    m_err = '0; m_yh = '0;
  endtask

  task automatic model_acc(input logic [31:0] yv,
                           input logic [31:0] yhv);
    longint d;
    d = longint'($signed(yv)) - longint'($signed(yhv));
    if (d < 0) d = -d;
    m_err = d[31:0];
    m_yh  = yhv;
    m_n++;
    if (m_n > WU && !m_lock) begin
      if (d <= TOLV) m_run++;
      else m_run = 0;
      if (m_run == SC) m_lock = 1;
    end
  endtask

  task automatic tick(input logic c, input logic s,
                      input logic [31:0] yv,
                      input logic [31:0] yhv);
    @(negedge clk);
    ce = c; stb = s; y = yv; yh = yhv;
    @(posedge clk);
    if (c && s && !rst) model_acc(yv, yhv);
    #1;
  endtask

  task automatic send(input logic [31:0] yv,
                      input logic [31:0] yhv);
    tick(1'b1, 1'b1, yv, yhv);
    tick(1'b1, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; ce = 1'b0; stb = 1'b0;
    repeat (n) @(posedge clk);
    model_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++;
    if (v !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%0b exp=0", v);
    end
    checks++;
    if (ea !== 32'd0) begin
      errors++; $display("FAIL reset_err got=%0h exp=0", ea);
    end
    checks++;
    if (sc !== 7'd0) begin
      errors++; $display("FAIL reset_cnt got=%0d exp=0", sc);
    end
    for (int i = 0; i < WU + SC - 1; i++) begin
      send(32'd1000, 32'd990);
      checks++;
      if (sc !== 7'(m_run)) begin
        errors++;
        $display("FAIL pre_lock_cnt i=%0d got=%0d exp=%0d",
                 i, sc, m_run);
      end
    end
    checks++;
    if (v !== 1'b0 || sc !== 7'd63) begin
      errors++;
      $display("FAIL pre_lock got v=%0b cnt=%0d exp v=0 cnt=63",
               v, sc);
    end
  endtask

  task automatic test_lock();
    tick(1'b1, 1'b1, 32'd1000, 32'd990);
    checks++;
    if (v !== 1'b0 || ea !== 32'd10) begin
      errors++;
      $display("FAIL lock_stage1 got v=%0b err=%0d exp v=0 err=10",
               v, ea);
    end
    tick(1'b1, 1'b0, 32'd0, 32'd0);
    checks++;
    if (v !== 1'b1 || sc !== 7'(SC) || !m_lock) begin
      errors++;
      $display("FAIL lock got v=%0b cnt=%0d exp v=1 cnt=%0d",
               v, sc, SC);
    end
  endtask

  task automatic test_sticky_ce();
    logic        c;
    logic [31:0] yv;
    for (int i = 0; i < 40; i++) begin
      c  = 1'($urandom_range(0, 1));
      yv = $urandom;
      tick(c, 1'b1, yv, yv ^ 32'h4000_0000);
      checks++;
      if (v !== 1'b1 || sc !== 7'(SC) || ea !== m_err
          || yo !== m_yh) begin
        errors++;
        $display("FAIL sticky i=%0d ce=%0b v=%0b cnt=%0d err=%0h/%0h yhat=%0h/%0h",
                 i, c, v, sc, ea, m_err, yo, m_yh);
      end
    end
  endtask

  task automatic test_boundary();
    do_reset(1);
    for (int i = 0; i < WU; i++) send($urandom, $urandom);
    checks++;
    if (sc !== 7'd0) begin
      errors++; $display("FAIL warmup_cnt got=%0d exp=0", sc);
    end
    send(32'd0, -32'sd1024);
    checks++;
    if (ea !== 32'd1024 || sc !== 7'd1) begin
      errors++;
      $display("FAIL tol_edge got err=%0d cnt=%0d exp 1024/1",
               ea, sc);
    end
    send(32'd0, -32'sd1025);
    checks++;
    if (ea !== 32'd1025 || sc !== 7'd0) begin
      errors++;
      $display("FAIL tol_over got err=%0d cnt=%0d exp 1025/0",
               ea, sc);
    end
  endtask

  task automatic test_extremes();
    send(32'd5, 32'd5);
    send(32'h7FFF_FFFF, 32'h8000_0000);
    checks++;
    if (ea !== 32'hFFFF_FFFF || sc !== 7'd0) begin
      errors++;
      $display("FAIL extreme_a got err=%0h cnt=%0d exp ffffffff/0",
               ea, sc);
    end
    send(32'd7, 32'd7);
    send(32'h8000_0000, 32'h7FFF_FFFF);
    checks++;
    if (ea !== 32'hFFFF_FFFF || sc !== 7'd0) begin
      errors++;
      $display("FAIL extreme_b got err=%0h cnt=%0d exp ffffffff/0",
               ea, sc);
    end
  endtask

  task automatic test_back_to_back();
    logic        c, s;
    logic [31:0] yv;
    int          off;
    do_reset(1);
    for (int i = 0; i < 600; i++) begin
      c   = ($urandom_range(0, 3) != 0);
      s   = ($urandom_range(0, 3) != 0);
      yv  = $urandom;
      off = int'($urandom_range(0, 2100)) - 1050;
      tick(c, s, yv, yv - 32'(off));
      checks++;
      if (ea !== m_err || yo !== m_yh) begin
        errors++;
        $display("FAIL b2b_stage1 i=%0d err=%0h/%0h yhat=%0h/%0h",
                 i, ea, m_err, yo, m_yh);
      end
    end
    tick(1'b1, 1'b0, 32'd0, 32'd0);
    tick(1'b1, 1'b0, 32'd0, 32'd0);
    checks++;
    if (sc !== 7'(m_run) || v !== m_lock) begin
      errors++;
      $display("FAIL b2b_state got cnt=%0d v=%0b exp cnt=%0d v=%0b",
               sc, v, m_run, m_lock);
    end
  endtask

  task automatic test_reset_locked_w0();
    do_reset(1);
    for (int i = 0; i < 4; i++) send(32'd200, 32'd180);
    checks++;
    if (v0 !== 1'b1 || sc0 !== 3'd4) begin
      errors++;
      $display("FAIL w0_lock got v=%0b cnt=%0d exp 1/4", v0, sc0);
    end
    tick(1'b1, 1'b1, 32'd100, 32'd100);
    @(negedge clk);
    rst = 1'b1; ce = 1'b1; stb = 1'b0;
    @(posedge clk);
    #1;
    model_rst();
    checks++;
    if (v0 !== 1'b0 || sc0 !== 3'd0) begin
      errors++;
      $display("FAIL w0_reset got v=%0b cnt=%0d exp 0/0", v0, sc0);
    end
    @(negedge clk);
    rst = 1'b0;
    tick(1'b1, 1'b0, 32'd0, 32'd0);
    checks++;
    if (sc0 !== 3'd0) begin
      errors++;
      $display("FAIL w0_pending got cnt=%0d exp=0", sc0);
    end
    send(32'd100, 32'd100);
    checks++;
    if (sc0 !== 3'd1 || v0 !== 1'b0) begin
      errors++;
      $display("FAIL w0_first got cnt=%0d v=%0b exp 1/0", sc0, v0);
    end
    checks++;
    if (sc !== 7'(m_run) || v !== 1'b0) begin
      errors++;
      $display("FAIL w16_after got cnt=%0d exp=%0d", sc, m_run);
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; stb = 1'b0;
    y = '0; yh = '0;
    model_rst();
    test_reset();
    test_lock();
    test_sticky_ce();
    test_boundary();
    test_extremes();
    test_back_to_back();
    test_reset_locked_w0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
